dadda_nxn_pipelined: RTL

Parametrised, pipelined Dadda-tree multiplier for WIDTH x WIDTH operands, producing a 2*WIDTH product. It succeeds the fixed 16x16 combinational Dadda multipliers: it adds configurable pipeline depth, a valid/ready handshake with full backpressure, and an optional two's-complement (Baugh-Wooley) mode. It sits between an operand producer and a result consumer in the datapath and accepts one product per cycle when not stalled.

---
 rtl/dadda_nxn_pipelined.sv | 221 ++++++++++++++++++++++
 1 files changed

// File: rtl/dadda_nxn_pipelined.sv
// Pipelined WIDTH x WIDTH Dadda-tree multiplier with valid/ready handshake.
// Ports: clk, rst (sync, active-high), in_valid/in_ready, a, b, signed_mode,
//        out_valid/out_ready, final_result (2*WIDTH-bit product).
// Optional Baugh-Wooley signed mode is compiled in by defining DADDA_SIGNED_EN.
module dadda_nxn_pipelined #(
    parameter int WIDTH  = 16,
    parameter int STAGES = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic               signed_mode,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] final_result
);

    localparam int PW   = 2 * WIDTH;
    localparam int MAXH = WIDTH + 1;
    localparam int ND   = 9;

    // Dadda height limit for step k: 2,3,4,6,9,13,19,28,42
    function automatic int dadda_d(input int k);
        int d;
        d = 2;
        for (int i = 0; i < k; i++) d = (d * 3) / 2;
        return d;
    endfunction

    logic             w_en;
    logic             r_vo;
    logic [PW-1:0]    r_res;
    logic [WIDTH-1:0] w_a, w_b;
    logic             w_v;

    // One global enable: every stage advances or every stage holds.
    assign w_en     = !r_vo || out_ready;
    assign in_ready = w_en && !rst;

`ifdef DADDA_SIGNED_EN
    logic w_s;
`else
    logic w_unused_sm;
    assign w_unused_sm = signed_mode;
`endif

    generate
        if (STAGES == 3) begin : g_in
            logic [WIDTH-1:0] r_a, r_b;
            logic             r_v;
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_v <= 1'b0;
                    r_a <= '0;
                    r_b <= '0;
                end else if (w_en) begin
                    r_v <= in_valid;
                    r_a <= a;
                    r_b <= b;
                end
            end
            assign w_a = r_a;
            assign w_b = r_b;
            assign w_v = r_v;
`ifdef DADDA_SIGNED_EN
            logic r_s;
            always_ff @(posedge clk) begin
                if (rst)       r_s <= 1'b0;
                else if (w_en) r_s <= signed_mode;
            end
            assign w_s = r_s;
`endif
        end else begin : g_in_bypass
            assign w_a = a;
            assign w_b = b;
            assign w_v = in_valid;
`ifdef DADDA_SIGNED_EN
            assign w_s = signed_mode;
`endif
        end
    endgenerate

    // Column-wise Dadda reduction. Each column is a bit stack: new bits are
    // appended above the current height, consumed bits are shifted off the
    // bottom, so no data-dependent indexing is needed.
    logic [MAXH-1:0] w_cur [PW];
    logic [MAXH-1:0] w_nxt [PW];
    int              w_hc  [PW];
    int              w_hn  [PW];
    logic [MAXH-1:0] w_src;
    int              w_av, w_out, w_d;
    logic            w_bit, w_sb, w_cb;
    logic [PW-1:0]   w_row0, w_row1;

    always_comb begin
        w_src  = '0;
        w_av   = 0;
        w_out  = 0;
        w_d    = 0;
        w_bit  = 1'b0;
        w_sb   = 1'b0;
        w_cb   = 1'b0;
        w_row0 = '0;
        w_row1 = '0;
        for (int i = 0; i < PW; i++) begin
            w_cur[i] = '0;
            w_nxt[i] = '0;
            w_hc[i]  = 0;
            w_hn[i]  = 0;
        end
        for (int i = 0; i < WIDTH; i++) begin
            for (int j = 0; j < WIDTH; j++) begin
                w_bit = w_a[j] & w_b[i];
`ifdef DADDA_SIGNED_EN
                // Baugh-Wooley: cross terms with exactly one MSB are inverted
                if ((i == WIDTH-1) != (j == WIDTH-1)) w_bit = w_bit ^ w_s;
`endif
                w_cur[i+j] = w_cur[i+j] | (MAXH'(w_bit) << w_hc[i+j]);
                w_hc[i+j]  = w_hc[i+j] + 1;
            end
        end
`ifdef DADDA_SIGNED_EN
        w_cur[WIDTH] = w_cur[WIDTH] | (MAXH'(w_s) << w_hc[WIDTH]);
        w_hc[WIDTH]  = w_hc[WIDTH] + 1;
        w_cur[PW-1]  = w_cur[PW-1] | (MAXH'(w_s) << w_hc[PW-1]);
        w_hc[PW-1]   = w_hc[PW-1] + 1;
`endif
        for (int k = ND-1; k >= 0; k--) begin
            w_d = dadda_d(k);
            for (int i = 0; i < PW; i++) begin
                w_nxt[i] = '0;
                w_hn[i]  = 0;
            end
            for (int i = 0; i < PW; i++) begin
                w_src = w_cur[i];
                w_av  = w_hc[i];
                for (int t = 0; t < MAXH; t++) begin
                    w_out = w_hn[i] + w_av;
                    if (w_out > w_d && w_av >= 2) begin
                        if (w_out == w_d + 1 || w_av == 2) begin
                            w_sb  = w_src[0] ^ w_src[1];
                            w_cb  = w_src[0] & w_src[1];
                            w_src = w_src >> 2;
                            w_av  = w_av - 2;
                        end else begin
                            w_sb  = ^w_src[2:0];
                            w_cb  = (w_src[0] & w_src[1]) |
                                    (w_src[2] & (w_src[0] ^ w_src[1]));
                            w_src = w_src >> 3;
                            w_av  = w_av - 3;
                        end
                        w_nxt[i] = w_nxt[i] | (MAXH'(w_sb) << w_hn[i]);
                        w_hn[i]  = w_hn[i] + 1;
                        // carry out of the top column is dropped
                        if (i < PW-1) begin
                            w_nxt[i+1] = w_nxt[i+1] | (MAXH'(w_cb) << w_hn[i+1]);
                            w_hn[i+1]  = w_hn[i+1] + 1;
                        end
                    end
                end
                w_nxt[i] = w_nxt[i] | (w_src << w_hn[i]);
                w_hn[i]  = w_hn[i] + w_av;
            end
            for (int i = 0; i < PW; i++) begin
                w_cur[i] = w_nxt[i];
                w_hc[i]  = w_hn[i];
            end
        end
        for (int i = 0; i < PW; i++) begin
            w_row0[i] = w_cur[i][0];
            w_row1[i] = w_cur[i][1];
        end
    end

    logic [PW-1:0] w_c0, w_c1, w_sum;
    logic          w_cv;

    generate
        if (STAGES >= 2) begin : g_mid
            logic [PW-1:0] r_r0, r_r1;
            logic          r_v1;
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_v1 <= 1'b0;
                    r_r0 <= '0;
                    r_r1 <= '0;
                end else if (w_en) begin
                    r_v1 <= w_v;
                    r_r0 <= w_row0;
                    r_r1 <= w_row1;
                end
            end
            assign w_c0 = r_r0;
            assign w_c1 = r_r1;
            assign w_cv = r_v1;
        end else begin : g_mid_bypass
            assign w_c0 = w_row0;
            assign w_c1 = w_row1;
            assign w_cv = w_v;
        end
    endgenerate

    assign w_sum = w_c0 + w_c1;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_vo  <= 1'b0;
            r_res <= '0;
        end else if (w_en) begin
            r_vo  <= w_cv;
            r_res <= w_sum;
        end
    end

    assign out_valid    = r_vo;
    assign final_result = r_res;

endmodule
